// File: rtl/avst_chk_pkg.sv
// avst_chk_pkg: shared types and helpers for the Avalon-ST packet checker.
//   chk_state_e : compare FSM states
//   beat_t      : beat record at the default geometry (32-bit data, 2-bit empty)
//   byte_mask() : valid-byte mask of an EOP beat, bit i = byte i counted from LSB
package avst_chk_pkg;

    localparam int BEAT_DATA_W  = 32;
    localparam int BEAT_EMPTY_W = 2;
    // Widest beat the mask helper supports (DATA_WIDTH <= 8*(MAX_BYTES-1)).
    localparam int MAX_BYTES    = 256;

    typedef enum logic [1:0] {
        IDLE,
        IN_PKT,
        DRAIN_EXP,
        DRAIN_ACT
    } chk_state_e;

    typedef struct packed {
        logic [BEAT_DATA_W-1:0]  data;
        logic                    sop;
        logic                    eop;
        logic [BEAT_EMPTY_W-1:0] empty;
    } beat_t;

    // First symbol sits in the MSBs, so 'empty' unused bytes are the lowest
    // 'empty' bytes: LSB-indexed byte i is valid iff empty <= i < nbytes.
    function automatic logic [MAX_BYTES-1:0] byte_mask(input int unsigned nbytes,
                                                       input int unsigned empty);
        logic [MAX_BYTES-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_BYTES; i++)
            m[i] = (i >= empty) && (i < nbytes);
        return m;
    endfunction

endpackage

// File: rtl/avst_sync_fifo.sv
// avst_sync_fifo: show-ahead synchronous FIFO; the head word is visible on
// rd_data whenever empty is low, rd_en pops it.
//   clk, reset_n : clock, async active-low reset
//   flush        : sync clear of both pointers (wins over wr_en/rd_en)
//   wr_en/wr_data: push (ignored when full)
//   rd_en/rd_data: pop (ignored when empty) / head word
//   full, empty  : occupancy flags
module avst_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    // One extra pointer bit separates full from empty.
    logic [AW:0]      wp, rp;

    assign empty   = (wp == rp);
    assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign rd_data = mem[rp[AW-1:0]];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wp <= '0;
            rp <= '0;
        end else if (flush) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (wr_en && !full)  wp <= wp + 1'b1;
            if (rd_en && !empty) rp <= rp + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !full && !flush)
            mem[wp[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/avst_packet_checker.sv
// avst_packet_checker: compares an expected and an actual Avalon-ST stream
// packet by packet and reports one pass/fail result per packet pair.
//   clk, reset_n                 : clock, async active-low reset
//   clear                        : sync flush of FIFOs, counters and FSM
//   exp_* / act_*                : expected / actual Avalon-ST sinks
//   result_valid/match/len       : one-cycle per-packet result, len = exp beats
//   pkt_count, err_count         : packet pairs compared / mismatching (saturating)
//   proto_err_count              : beats discarded outside a packet (saturating)
// Optional (define AVST_CHK_MISMATCH_CAPTURE_EN):
//   mis_beat_idx, mis_exp_data, mis_act_data : first bad beat of the latest
//   failing packet; a pure length mismatch reports idx = shorter length, data 0.
module avst_packet_checker
    import avst_chk_pkg::*;
#(
    parameter int DATA_WIDTH  = BEAT_DATA_W,
    parameter int EMPTY_WIDTH = (DATA_WIDTH / 8 > 1) ? $clog2(DATA_WIDTH / 8) : 1,
    parameter int FIFO_DEPTH  = 8,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   clear,
    input  logic                   exp_valid,
    output logic                   exp_ready,
    input  logic [DATA_WIDTH-1:0]  exp_data,
    input  logic                   exp_sop,
    input  logic                   exp_eop,
    input  logic [EMPTY_WIDTH-1:0] exp_empty,
    input  logic                   act_valid,
    output logic                   act_ready,
    input  logic [DATA_WIDTH-1:0]  act_data,
    input  logic                   act_sop,
    input  logic                   act_eop,
    input  logic [EMPTY_WIDTH-1:0] act_empty,
    output logic                   result_valid,
    output logic                   result_match,
    output logic [CNT_WIDTH-1:0]   result_len,
    output logic [CNT_WIDTH-1:0]   pkt_count,
    output logic [CNT_WIDTH-1:0]   err_count,
    output logic [CNT_WIDTH-1:0]   proto_err_count
`ifdef AVST_CHK_MISMATCH_CAPTURE_EN
    ,
    output logic [CNT_WIDTH-1:0]   mis_beat_idx,
    output logic [DATA_WIDTH-1:0]  mis_exp_data,
    output logic [DATA_WIDTH-1:0]  mis_act_data
`endif
);
    localparam int NB = DATA_WIDTH / 8;
    localparam int BW = DATA_WIDTH + 2 + EMPTY_WIDTH;

    typedef struct packed {
        logic [DATA_WIDTH-1:0]  data;
        logic                   sop;
        logic                   eop;
        logic [EMPTY_WIDTH-1:0] empty;
    } beat_s;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    chk_state_e           state, nxt_state;
    logic [CNT_WIDTH-1:0] beat_cnt, nxt_cnt, base_cnt;
    logic                 mis, nxt_mis, base_mis;
    logic                 out_en;

    beat_s exp_head, act_head;
    logic  exp_full, exp_mt, act_full, act_mt;
    logic  exp_pop, act_pop, do_cmp, discard, fin, one_eop, beat_mis;

    // ready is held low until the first clock after reset release.
    assign exp_ready = out_en && !exp_full;
    assign act_ready = out_en && !act_full;

    avst_sync_fifo #(.WIDTH(BW), .DEPTH(FIFO_DEPTH)) u_exp_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (clear),
        .wr_en   (exp_valid && exp_ready),
        .wr_data ({exp_data, exp_sop, exp_eop, exp_empty}),
        .rd_en   (exp_pop),
        .rd_data (exp_head),
        .full    (exp_full),
        .empty   (exp_mt)
    );

    avst_sync_fifo #(.WIDTH(BW), .DEPTH(FIFO_DEPTH)) u_act_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (clear),
        .wr_en   (act_valid && act_ready),
        .wr_data ({act_data, act_sop, act_eop, act_empty}),
        .rd_en   (act_pop),
        .rd_data (act_head),
        .full    (act_full),
        .empty   (act_mt)
    );

    // ---- beat compare ----------------------------------------------------
    logic [MAX_BYTES-1:0]  bm_full;
    logic [DATA_WIDTH-1:0] dmask;
    logic                  unused_bm_hi;

    always_comb begin
        bm_full = byte_mask(NB, 32'(exp_head.empty));
        dmask   = '1;
        for (int b = 0; b < NB; b++)
            dmask[8*b +: 8] = {8{exp_head.eop ? bm_full[b] : 1'b1}};
    end
    assign unused_bm_hi = &{1'b0, bm_full[MAX_BYTES-1:NB]};

    // Any sop inside a packet is a mismatch: there is no resync mid-packet.
    assign beat_mis = (exp_head.sop   != act_head.sop)
                   || (exp_head.eop   != act_head.eop)
                   || (exp_head.empty != act_head.empty)
                   || (|((exp_head.data ^ act_head.data) & dmask))
                   || ((state == IN_PKT) && (exp_head.sop || act_head.sop));

    assign one_eop  = exp_head.eop ^ act_head.eop;
    assign base_cnt = (state == IDLE) ? '0 : beat_cnt;
    assign base_mis = (state == IDLE) ? 1'b0 : mis;

    // ---- pop decode / next state ----------------------------------------
    always_comb begin
        exp_pop   = 1'b0;
        act_pop   = 1'b0;
        do_cmp    = 1'b0;
        discard   = 1'b0;
        fin       = 1'b0;
        nxt_state = state;
        nxt_cnt   = beat_cnt;
        nxt_mis   = mis;
        case (state)
            IDLE, IN_PKT: begin
                // Stray heads in IDLE are dropped one per cycle, exp first.
                if (state == IDLE && !exp_mt && !exp_head.sop) begin
                    exp_pop = 1'b1;
                    discard = 1'b1;
                end else if (state == IDLE && !act_mt && !act_head.sop) begin
                    act_pop = 1'b1;
                    discard = 1'b1;
                end else if (!exp_mt && !act_mt) begin
                    do_cmp  = 1'b1;
                    exp_pop = 1'b1;
                    act_pop = 1'b1;
                    nxt_cnt = sat_inc(base_cnt);
                    nxt_mis = base_mis || beat_mis;
                    if (exp_head.eop && act_head.eop) begin
                        fin       = 1'b1;
                        nxt_state = IDLE;
                    end else if (exp_head.eop) begin
                        nxt_mis   = 1'b1;
                        nxt_state = DRAIN_ACT;
                    end else if (act_head.eop) begin
                        nxt_mis   = 1'b1;
                        nxt_state = DRAIN_EXP;
                    end else begin
                        nxt_state = IN_PKT;
                    end
                end
            end
            DRAIN_EXP: begin
                exp_pop = !exp_mt;
                if (!exp_mt) begin
                    nxt_cnt = sat_inc(beat_cnt);
                    if (exp_head.eop) begin
                        fin       = 1'b1;
                        nxt_state = IDLE;
                    end
                end
            end
            DRAIN_ACT: begin
                act_pop = !act_mt;
                if (!act_mt && act_head.eop) begin
                    fin       = 1'b1;
                    nxt_state = IDLE;
                end
            end
            default: nxt_state = IDLE;
        endcase
    end

    // ---- state, result and counters -------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            beat_cnt        <= '0;
            mis             <= 1'b0;
            out_en          <= 1'b0;
            result_valid    <= 1'b0;
            result_match    <= 1'b0;
            result_len      <= '0;
            pkt_count       <= '0;
            err_count       <= '0;
            proto_err_count <= '0;
        end else begin
            out_en       <= 1'b1;
            result_valid <= 1'b0;
            if (clear) begin
                state           <= IDLE;
                beat_cnt        <= '0;
                mis             <= 1'b0;
                pkt_count       <= '0;
                err_count       <= '0;
                proto_err_count <= '0;
            end else begin
                state    <= nxt_state;
                beat_cnt <= nxt_cnt;
                mis      <= nxt_mis;
                if (discard)
                    proto_err_count <= sat_inc(proto_err_count);
                if (fin) begin
                    result_valid <= 1'b1;
                    result_match <= !nxt_mis;
                    result_len   <= nxt_cnt;
                    pkt_count    <= sat_inc(pkt_count);
                    if (nxt_mis)
                        err_count <= sat_inc(err_count);
                end
            end
        end
    end

`ifdef AVST_CHK_MISMATCH_CAPTURE_EN
    logic [CNT_WIDTH-1:0]  first_idx, cur_idx;
    logic [DATA_WIDTH-1:0] first_exp, first_act, cur_exp, cur_act;

    // First mismatch of the packet in flight; a beat where only one side
    // ends is reported as a length mismatch rather than a data mismatch.
    always_comb begin
        cur_idx = first_idx;
        cur_exp = first_exp;
        cur_act = first_act;
        if (do_cmp && !base_mis) begin
            if (one_eop) begin
                cur_idx = nxt_cnt;
                cur_exp = '0;
                cur_act = '0;
            end else if (beat_mis) begin
                cur_idx = base_cnt;
                cur_exp = exp_head.data;
                cur_act = act_head.data;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            first_idx    <= '0;
            first_exp    <= '0;
            first_act    <= '0;
            mis_beat_idx <= '0;
            mis_exp_data <= '0;
            mis_act_data <= '0;
        end else begin
            first_idx <= cur_idx;
            first_exp <= cur_exp;
            first_act <= cur_act;
            if (!clear && fin && nxt_mis) begin
                mis_beat_idx <= cur_idx;
                mis_exp_data <= cur_exp;
                mis_act_data <= cur_act;
            end
        end
    end
`endif

endmodule
